// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction prefetch buffer
//
// Purpose: common definitions for if_prefetch_buf and its FIFO.
// Ports:   none (package).
package if_pkg;

  localparam int              XLEN               = 32;
  localparam logic [XLEN-1:0] INST_NOP           = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

  // One buffered fetch result: where it came from and what was read.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered head and occupancy count
//
// Purpose: power-of-two deep first-in first-out store, no read bypass.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr_i     synchronous flush, same effect as rst
//   push_i    write data_i at the tail (accepted if not full, or full with a pop)
//   pop_i     drop the head (ignored while empty)
//   data_o    head entry (undefined while empty)
//   full_o, empty_o, count_o  occupancy status
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/if_prefetch_buf.sv
// rtl/if_prefetch_buf.sv - instruction prefetch queue between imem and fetch
//
// Purpose: owns the fetch PC, issues in-order word requests to instruction
// memory, buffers up to DEPTH {addr, inst} results and flushes on redirect,
// discarding responses that were already in flight.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   redirect_i, redirect_addr_i  flush and restart fetch at a new address
//   mem_req_o, mem_addr_o        request valid and word-aligned address
//   mem_gnt_i                    request accepted this cycle
//   mem_rvalid_i, mem_rdata_i    in-order response valid and data
//   inst_valid_o, inst_o, inst_addr_o  queue head
//   inst_ready_i                 consumer pops the head
module if_prefetch_buf
  import if_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  localparam int          CW         = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_CAP = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    push_entry, head_entry;

  logic [CW-1:0]   live;
  logic [CW:0]     occupancy;
  logic            grant, push, pop;

  // Only non-discarded in-flight requests will land in the queue, so they
  // plus what is already buffered must fit in DEPTH.
  assign live      = inflight_q - discard_q;
  assign occupancy = {1'b0, live} + {1'b0, fifo_count};

  assign mem_req_o  = !rst && !redirect_i && (occupancy < CREDIT_CAP);
  assign mem_addr_o = fetch_pc_q;
  assign grant      = mem_req_o && mem_gnt_i;

  // Redirect wins over every queue update: the FIFO clear drops same-cycle
  // pushes and pops.
  assign push       = mem_rvalid_i && (discard_q == '0) && !redirect_i;
  assign pop        = inst_ready_i && !redirect_i;
  assign push_entry = '{addr: resp_pc_q, inst: mem_rdata_i};

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redirect_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Head storage is not reset; present zeros whenever nothing is buffered.
  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? '0 : head_entry.inst;
  assign inst_addr_o  = fifo_empty ? '0 : head_entry.addr;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_addr_i);
      resp_pc_d  = word_align(redirect_addr_i);
      // A response landing this cycle retires one outstanding request;
      // everything still outstanding belongs to the old stream.
      discard_d  = inflight_q - CW'(mem_rvalid_i);
      inflight_d = inflight_q - CW'(mem_rvalid_i);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      inflight_d = inflight_q + CW'(grant) - CW'(mem_rvalid_i);
      if (mem_rvalid_i) begin
        if (discard_q != '0) discard_d = discard_q - CW'(1);
        else                 resp_pc_d = resp_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_ADDR;
      resp_pc_q  <= RESET_ADDR;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // Credit accounting must never let a response arrive with the queue full.
  assert property (@(posedge clk) disable iff (rst || redirect_i)
                   !(push && fifo_full && !inst_ready_i));

endmodule

// File: tb/tb_if_prefetch_buf.sv
// tb/tb_if_prefetch_buf.sv - self-checking bench for if_prefetch_buf
module tb_if_prefetch_buf;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = 32'h0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b1;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i = 1'b1;

  always #5 clk = ~clk;

  if_prefetch_buf #(.DEPTH(DEPTH), .RESET_ADDR(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_addr_o     (inst_addr_o),
    .inst_ready_i    (inst_ready_i)
  );

  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { int due; logic [31:0] addr; } mreq_t;

  pend_t       pend[$];
  logic [31:0] mfifo[$];
  logic [31:0] m_pc = 32'h0;
  mreq_t       mq[$];
  int          cyc = 0;
  int          lat = 1;
  logic        req_seen = 1'b0;
  logic [31:0] addr_seen = 32'h0;
  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];
  bit          cmp_en = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic bit model_req();
    int live = 0;
    foreach (pend[i]) if (!pend[i].stale) live++;
    return !rst && !redirect_i && ((live + mfifo.size()) < DEPTH);
  endfunction

  function automatic logic [31:0] gl(input int i);
    return (i < gnt_log.size()) ? gnt_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pl(input int i);
    return (i < pop_log.size()) ? pop_log[i] : 32'hDEAD_BEEF;
  endfunction

  // Model update and memory responder, both on the sampled cycle inputs.
  always @(posedge clk) begin
    bit    g;
    pend_t r;
    g = model_req() && mem_gnt_i;
    if (rst) begin
      m_pc = 32'h0;
      pend.delete();
      mfifo.delete();
    end else if (redirect_i) begin
      mfifo.delete();
      if (mem_rvalid_i && pend.size() > 0) void'(pend.pop_front());
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_pc = {redirect_addr_i[31:2], 2'b00};
    end else begin
      if (inst_ready_i && mfifo.size() > 0) void'(mfifo.pop_front());
      if (mem_rvalid_i && pend.size() > 0) begin
        r = pend.pop_front();
        if (!r.stale) mfifo.push_back(r.addr);
      end
      if (g) begin
        pend.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    if (rst) mq.delete();
    else if (req_seen && mem_gnt_i) mq.push_back('{due: cyc + lat - 1, addr: addr_seen});
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mq[0].addr ^ KEY;
      void'(mq.pop_front());
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
    end
  end

  // Per-cycle comparison against the model, plus handshake logs.
  always @(negedge clk) begin
    req_seen  = mem_req_o;
    addr_seen = mem_addr_o;
    if (!rst && mem_req_o && mem_gnt_i) gnt_log.push_back(mem_addr_o);
    if (!rst && !redirect_i && inst_valid_o && inst_ready_i) pop_log.push_back(inst_addr_o);
    if (cmp_en) begin
      chk("req", {31'h0, mem_req_o}, {31'h0, model_req()});
      if (model_req()) chk("addr", mem_addr_o, m_pc);
      chk("valid", {31'h0, inst_valid_o}, {31'h0, mfifo.size() > 0});
      if (mfifo.size() > 0) begin
        chk("inst_addr", inst_addr_o, mfifo[0]);
        chk("inst", inst_o, mfifo[0] ^ KEY);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(2);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_iaddr", inst_addr_o, 32'h0);
    chk("rst_maddr", mem_addr_o, 32'h0);

    // Zero-wait streaming
    tick(1); rst = 1'b0; lat = 1; inst_ready_i = 1'b1;
    @(negedge clk);
    chk("s1_req0", {31'h0, mem_req_o}, 32'h1);
    chk("s1_addr0", mem_addr_o, 32'h0);
    tick(1); @(negedge clk);
    chk("s1_addr1", mem_addr_o, 32'h4);
    tick(1); @(negedge clk);
    chk("s1_addr2", mem_addr_o, 32'h8);
    chk("s1_iaddr0", inst_addr_o, 32'h0);
    chk("s1_inst0", inst_o, 32'hA5A5_0000);
    tick(1); @(negedge clk);
    chk("s1_addr3", mem_addr_o, 32'hC);
    chk("s1_iaddr1", inst_addr_o, 32'h4);
    chk("s1_inst1", inst_o, 32'hA5A5_0004);
    tick(1); @(negedge clk);
    chk("s1_iaddr2", inst_addr_o, 32'h8);

    // Consumer stalled: credit stops at DEPTH grants
    tick(1); rst = 1'b1;
    tick(1); rst = 1'b0; inst_ready_i = 1'b0; gnt_log.delete(); pop_log.delete();
    tick(20); @(negedge clk);
    chk("s2_ngnt", gnt_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("s2_gnt", gl(i), 32'(4 * i));
    chk("s2_req", {31'h0, mem_req_o}, 32'h0);
    chk("s2_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("s2_iaddr", inst_addr_o, 32'h0);
    tick(1); inst_ready_i = 1'b1; pop_log.delete();
    tick(10); @(negedge clk);
    for (int i = 0; i < 4; i++) chk("s2_pop", pl(i), 32'(4 * i));
    chk("s2_resume", gl(4), 32'h10);

    // Redirect with two requests in flight, 3-cycle memory
    tick(1); rst = 1'b1;
    tick(1); rst = 1'b0; lat = 3;
    tick(2); redirect_i = 1'b1; redirect_addr_i = 32'h0000_0103; pop_log.delete();
    @(negedge clk);
    chk("s3_req_redir", {31'h0, mem_req_o}, 32'h0);
    tick(1); redirect_i = 1'b0;
    @(negedge clk);
    chk("s3_req", {31'h0, mem_req_o}, 32'h1);
    chk("s3_addr", mem_addr_o, 32'h100);
    tick(12); @(negedge clk);
    chk("s3_pop0", pl(0), 32'h100);
    chk("s3_pop1", pl(1), 32'h104);

    // Redirect coinciding with a stale response and a pop
    tick(1); rst = 1'b1;
    tick(1); rst = 1'b0; lat = 3;
    tick(4); redirect_i = 1'b1; redirect_addr_i = 32'h0000_0200; pop_log.delete();
    @(negedge clk);
    chk("s4_valid_pre", {31'h0, inst_valid_o}, 32'h1);
    tick(1); redirect_i = 1'b0;
    @(negedge clk);
    chk("s4_valid_post", {31'h0, inst_valid_o}, 32'h0);
    tick(12); @(negedge clk);
    chk("s4_pop0", pl(0), 32'h200);
    chk("s4_pop1", pl(1), 32'h204);

    // Address wrap
    tick(1); rst = 1'b1;
    tick(1); rst = 1'b0; lat = 1;
    redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFF8; gnt_log.delete(); pop_log.delete();
    tick(1); redirect_i = 1'b0;
    tick(8); @(negedge clk);
    chk("s5_gnt0", gl(0), 32'hFFFF_FFF8);
    chk("s5_gnt1", gl(1), 32'hFFFF_FFFC);
    chk("s5_gnt2", gl(2), 32'h0000_0000);
    chk("s5_pop0", pl(0), 32'hFFFF_FFF8);
    chk("s5_pop1", pl(1), 32'hFFFF_FFFC);
    chk("s5_pop2", pl(2), 32'h0000_0000);

    // Reset with entries buffered and requests in flight
    tick(1); rst = 1'b1;
    tick(1); rst = 1'b0; lat = 2; inst_ready_i = 1'b0;
    tick(4); rst = 1'b1;
    @(negedge clk);
    chk("s6_req_in_rst", {31'h0, mem_req_o}, 32'h0);
    chk("s6_valid_in_rst", {31'h0, inst_valid_o}, 32'h1);
    tick(1); @(negedge clk);
    chk("s6_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("s6_req", {31'h0, mem_req_o}, 32'h0);
    chk("s6_inst", inst_o, 32'h0);
    chk("s6_iaddr", inst_addr_o, 32'h0);
    chk("s6_maddr", mem_addr_o, 32'h0);
    tick(1); rst = 1'b0; gnt_log.delete();
    @(negedge clk);
    chk("s6_req_rel", {31'h0, mem_req_o}, 32'h1);
    chk("s6_addr_rel", mem_addr_o, 32'h0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
